// File: rtl/cpu_io_mux_if.sv
// CPU I/O bus plus channel request/ack bundle for cpu_io_mux; slave = the mux, master = CPU/channel side.
// wait_n exists only when CPU_IO_MUX_WAIT_EN is defined.
interface cpu_io_mux_if #(
    parameter int NUM_CH = 4
);
    logic [5:0]          A;
    logic                rd_iorq_n;
    logic                wr_iorq_n;
    logic [7:0]          cd_in;
    logic [7:0]          cd_out;
    logic                cd_oe;
    logic                cs_n;
    logic [NUM_CH-1:0]   ch_req;
    logic                ch_wr;
    logic [7:0]          ch_data_out;
    logic [NUM_CH*8-1:0] ch_data_in;
    logic [NUM_CH-1:0]   ch_ack;
`ifdef CPU_IO_MUX_WAIT_EN
    logic                wait_n;

    modport slave (
        input  A, rd_iorq_n, wr_iorq_n, cd_in, ch_data_in, ch_ack,
        output cd_out, cd_oe, cs_n, ch_req, ch_wr, ch_data_out, wait_n
    );
    modport master (
        output A, rd_iorq_n, wr_iorq_n, cd_in, ch_data_in, ch_ack,
        input  cd_out, cd_oe, cs_n, ch_req, ch_wr, ch_data_out, wait_n
    );
`else
    modport slave (
        input  A, rd_iorq_n, wr_iorq_n, cd_in, ch_data_in, ch_ack,
        output cd_out, cd_oe, cs_n, ch_req, ch_wr, ch_data_out
    );
    modport master (
        output A, rd_iorq_n, wr_iorq_n, cd_in, ch_data_in, ch_ack,
        input  cd_out, cd_oe, cs_n, ch_req, ch_wr, ch_data_out
    );
`endif
endinterface

// File: rtl/cpu_io_mux.sv
// cpu_io_mux: syncs Z80 IORQ strobes, decodes A[7:2] onto NUM_CH channels, one-shot req / ack with timeout.
// Latency: ch_req SYNC_STAGES+1 clk after the strobe pin falls; cd_oe/cd_out the cycle after ch_ack.
// Backpressure: cycle parks in WAIT until ch_ack or ACK_TIMEOUT; wait_n stalls the CPU when CPU_IO_MUX_WAIT_EN.
module cpu_io_mux #(
    parameter int                  NUM_CH      = 4,
    parameter logic [NUM_CH*6-1:0] CH_BASE     = {NUM_CH{6'h00}},
    parameter logic [NUM_CH*6-1:0] CH_MASK     = {NUM_CH{6'h3F}},
    parameter int                  SYNC_STAGES = 2,
    parameter int                  ACK_TIMEOUT = 15,
    parameter logic [7:0]          IDLE_DATA   = 8'hFF
) (
    input  logic         clk,
    input  logic         reset_n,
    cpu_io_mux_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    // cnt holds (WAIT cycles so far - 1) while in WAIT
    localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t              state, state_nxt;
    logic [SYNC_STAGES-1:0] rd_sync, wr_sync;
    logic                rd_s, wr_s, rd_prev, wr_prev;
    logic                start_rd, start_wr, start_hit;
    logic                released, ack_hit, timeout;
    logic [NUM_CH-1:0]   match, sel;
    logic                is_wr;
    logic [7:0]          wr_data, rd_data, ack_data, cnt;
    logic [NUM_CH-1:0]   ch_req;
    logic                ch_wr, cs_n, cd_oe;

    assign rd_s = rd_sync[SYNC_STAGES-1];
    assign wr_s = wr_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_sync <= '1;
            wr_sync <= '1;
            rd_prev <= 1'b1;
            wr_prev <= 1'b1;
        end else begin
            rd_sync <= {rd_sync[SYNC_STAGES-2:0], bus.rd_iorq_n};
            wr_sync <= {wr_sync[SYNC_STAGES-2:0], bus.wr_iorq_n};
            rd_prev <= rd_s;
            wr_prev <= wr_s;
        end
    end

    // a start needs the other strobe idle, so both-low never decodes
    assign start_rd = rd_prev & ~rd_s & wr_s;
    assign start_wr = wr_prev & ~wr_s & rd_s;

    always_comb begin
        match = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (((bus.A ^ CH_BASE[i*6 +: 6]) & CH_MASK[i*6 +: 6]) == 6'h00) begin
                match    = '0;
                match[i] = 1'b1;
            end
        end
    end

    always_comb begin
        ack_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel[i]) ack_data = ack_data | bus.ch_data_in[i*8 +: 8];
        end
    end

    assign start_hit = (state == S_IDLE) & (start_rd | start_wr) & (|match);
    assign released  = is_wr ? wr_s : rd_s;
    assign ack_hit   = |(bus.ch_ack & sel);
    assign timeout   = (cnt == TO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start_hit) state_nxt = S_REQ;
            S_REQ:  state_nxt = released ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (released)                state_nxt = S_IDLE;
                else if (ack_hit || timeout) state_nxt = S_HOLD;
            end
            S_HOLD: if (released) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel     <= '0;
            is_wr   <= 1'b0;
            wr_data <= 8'h00;
            rd_data <= 8'h00;
            cnt     <= 8'h00;
        end else begin
            if (start_hit) begin
                sel   <= match;
                is_wr <= start_wr;
                if (start_wr) wr_data <= bus.cd_in;
            end
            cnt <= (state == S_WAIT) ? cnt + 8'd1 : 8'd0;
            // ack wins over a coincident timeout
            if (state == S_WAIT && !released && !is_wr) begin
                if (ack_hit)      rd_data <= ack_data;
                else if (timeout) rd_data <= IDLE_DATA;
            end
        end
    end

    always_comb begin
        ch_req = '0;
        ch_wr  = 1'b0;
        cs_n   = 1'b1;
        cd_oe  = 1'b0;
        case (state)
            S_REQ: begin
                ch_req = sel;
                ch_wr  = is_wr;
                cs_n   = 1'b0;
            end
            S_WAIT: cs_n = 1'b0;
            S_HOLD: begin
                cs_n  = 1'b0;
                cd_oe = ~is_wr;
            end
            default: ;
        endcase
    end

    assign bus.ch_req      = ch_req;
    assign bus.ch_wr       = ch_wr;
    assign bus.cs_n        = cs_n;
    assign bus.cd_oe       = cd_oe;
    assign bus.cd_out      = rd_data;
    assign bus.ch_data_out = wr_data;

`ifdef CPU_IO_MUX_WAIT_EN
    assign bus.wait_n = ~(start_hit | (((state == S_REQ) | (state == S_WAIT)) & ~released));
`endif

endmodule

// File: tb/tb_cpu_io_mux.sv
// Bench for cpu_io_mux: transaction-level model checked every cycle plus hand-computed literals per scenario.
// Channel map: ch0 0x10, ch1 0x26, ch2 0x30, ch3 0x10..0x13.
module tb_cpu_io_mux;
    localparam int NUM_CH = 4;
    localparam int SYNC   = 2;
    localparam int TMO    = 15;
    localparam logic [5:0] BASE [4] = '{6'h10, 6'h26, 6'h30, 6'h10};
    localparam logic [5:0] MASK [4] = '{6'h3F, 6'h3F, 6'h3F, 6'h3C};

    logic clk, reset_n;
    cpu_io_mux_if #(.NUM_CH(NUM_CH)) bus ();

    cpu_io_mux #(
        .NUM_CH(NUM_CH),
        .CH_BASE({6'h10, 6'h30, 6'h26, 6'h10}),
        .CH_MASK({6'h3C, 6'h3F, 6'h3F, 6'h3F}),
        .SYNC_STAGES(SYNC),
        .ACK_TIMEOUT(TMO),
        .IDLE_DATA(8'hFF)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;
    bit pin_rd [0:4095];
    bit pin_wr [0:4095];

    // model: one outstanding CPU cycle, age 0 = request cycle
    bit         m_act = 0, m_hold = 0, m_wr = 0;
    int         m_age = 0, m_ch = 0;
    logic [7:0] m_wdata = 8'h00, m_rdata = 8'h00;

    int         ack_delay = -1;
    int         req_count, req_cyc, oe_count, oe_cyc, cs_low;
    logic [3:0] req_val;
    logic       req_wr;
    logic [7:0] req_data, oe_data;
    int         c0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic bit s_rd(input int j);
        int i;
        i = j - SYNC + 1;
        if (i < 0) return 1'b1;
        return pin_rd[i];
    endfunction

    function automatic bit s_wr(input int j);
        int i;
        i = j - SYNC + 1;
        if (i < 0) return 1'b1;
        return pin_wr[i];
    endfunction

    function automatic int decode(input logic [5:0] a);
        for (int i = 0; i < NUM_CH; i++)
            if (((a ^ BASE[i]) & MASK[i]) == 6'h00) return i;
        return -1;
    endfunction

    task automatic model_step();
        int  k;
        bit  rel, st_rd, st_wr;
        int  ch;
        k = cyc;
        pin_rd[k] = reset_n ? bus.rd_iorq_n : 1'b1;
        pin_wr[k] = reset_n ? bus.wr_iorq_n : 1'b1;
        if (!reset_n) begin
            m_act  = 0;
            m_hold = 0;
        end else if (m_act) begin
            rel = m_wr ? s_wr(k - 1) : s_rd(k - 1);
            if (rel) m_act = 0;
            else if (!m_hold && m_age >= 1 && bus.ch_ack[m_ch]) begin
                m_hold  = 1;
                m_rdata = bus.ch_data_in[m_ch*8 +: 8];
            end else if (!m_hold && m_age == TMO) begin
                m_hold  = 1;
                m_rdata = 8'hFF;
            end
            m_age++;
        end else begin
            st_rd = s_rd(k - 2) && !s_rd(k - 1) && s_wr(k - 1);
            st_wr = s_wr(k - 2) && !s_wr(k - 1) && s_rd(k - 1);
            ch = decode(bus.A);
            if ((st_rd || st_wr) && ch >= 0) begin
                m_act   = 1;
                m_hold  = 0;
                m_age   = 0;
                m_ch    = ch;
                m_wr    = st_wr;
                if (st_wr) m_wdata = bus.cd_in;
            end
        end
    endtask

    task automatic compare_step();
        logic [3:0] e_req;
        bit         e_oe;
`ifdef CPU_IO_MUX_WAIT_EN
        bit         st, rel;
`endif
        if (!reset_n) begin
            chk("rst_cs_n", bus.cs_n, 1);
            chk("rst_cd_oe", bus.cd_oe, 0);
            chk("rst_ch_req", bus.ch_req, 0);
        end else begin
            e_req = (m_act && !m_hold && m_age == 0) ? (4'b0001 << m_ch) : 4'b0000;
            e_oe  = m_act && m_hold && !m_wr;
            chk("cs_n", bus.cs_n, !m_act);
            chk("ch_req", bus.ch_req, e_req);
            chk("cd_oe", bus.cd_oe, e_oe);
            if (e_req != 4'b0000) begin
                chk("ch_wr", bus.ch_wr, m_wr);
                if (m_wr) chk("ch_data_out", bus.ch_data_out, m_wdata);
            end
            if (e_oe) chk("cd_out", bus.cd_out, m_rdata);
`ifdef CPU_IO_MUX_WAIT_EN
            st  = !m_act && decode(bus.A) >= 0 &&
                  ((s_rd(cyc - 1) && !s_rd(cyc) && s_wr(cyc)) ||
                   (s_wr(cyc - 1) && !s_wr(cyc) && s_rd(cyc)));
            rel = m_wr ? s_wr(cyc) : s_rd(cyc);
            chk("wait_n", bus.wait_n, !(st || (m_act && !m_hold && !rel)));
`endif
        end
        if (bus.ch_req != 4'b0000) begin
            if (req_count == 0) begin
                req_cyc  = cyc;
                req_val  = bus.ch_req;
                req_wr   = bus.ch_wr;
                req_data = bus.ch_data_out;
            end
            req_count++;
        end
        if (bus.cd_oe) begin
            if (oe_count == 0) begin
                oe_cyc  = cyc;
                oe_data = bus.cd_out;
            end
            oe_count++;
        end
        if (!bus.cs_n) cs_low++;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (cyc < 4096) model_step();
    end

    initial forever begin
        @(negedge clk);
        compare_step();
    end

    // channel responder: acks the requested channel ack_delay cycles after ch_req
    initial begin
        logic [3:0] r;
        bus.ch_ack = '0;
        forever begin
            @(negedge clk);
            if (bus.ch_req != 4'b0000 && ack_delay >= 0) begin
                r = bus.ch_req;
                repeat (ack_delay) @(posedge clk);
                #2 bus.ch_ack = r;
                @(posedge clk);
                #2 bus.ch_ack = '0;
            end
        end
    end

    task automatic clear_mon();
        req_count = 0;
        oe_count  = 0;
        cs_low    = 0;
        req_cyc   = -1;
        oe_cyc    = -1;
        req_val   = 4'h0;
        req_wr    = 1'b0;
        req_data  = 8'h00;
        oe_data   = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic io(input bit wr, input logic [5:0] a, input logic [7:0] d, input int low, output int start);
        clear_mon();
        bus.A     = a;
        bus.cd_in = d;
        if (wr) bus.wr_iorq_n = 1'b0;
        else    bus.rd_iorq_n = 1'b0;
        start = cyc;
        idle(low);
        bus.rd_iorq_n = 1'b1;
        bus.wr_iorq_n = 1'b1;
        idle(6);
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.A          = 6'h00;
        bus.rd_iorq_n  = 1'b1;
        bus.wr_iorq_n  = 1'b1;
        bus.cd_in      = 8'h00;
        bus.ch_data_in = {8'h44, 8'h33, 8'hC3, 8'h11};
        clear_mon();
        #1;
        chk("reset_cs_n", bus.cs_n, 1);
        chk("reset_cd_oe", bus.cd_oe, 0);
        chk("reset_ch_req", bus.ch_req, 0);
        chk("reset_cd_out", bus.cd_out, 8'h00);
        chk("reset_ch_data_out", bus.ch_data_out, 8'h00);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        idle(3);

        // write to ch1, ack 2 cycles after req
        ack_delay = 2;
        io(1'b1, 6'h26, 8'h5A, 10, c0);
        chk("wr_req_count", req_count, 1);
        chk("wr_req_val", req_val, 4'b0010);
        chk("wr_ch_wr", req_wr, 1);
        chk("wr_data", req_data, 8'h5A);
        chk("wr_latency", req_cyc - c0, 3);
        chk("wr_oe_count", oe_count, 0);
        chk("wr_cs_low", cs_low, 10);

        // read from ch1, ack after 3 cycles
        ack_delay = 3;
        io(1'b0, 6'h26, 8'h00, 10, c0);
        chk("rd_req_val", req_val, 4'b0010);
        chk("rd_ch_wr", req_wr, 0);
        chk("rd_oe_latency", oe_cyc - c0, 7);
        chk("rd_data", oe_data, 8'hC3);
        chk("rd_oe_count", oe_count, 6);
        chk("rd_cs_low", cs_low, 10);

        // read from ch2, never acked
        ack_delay = -1;
        io(1'b0, 6'h30, 8'h00, 25, c0);
        chk("to_req_val", req_val, 4'b0100);
        chk("to_oe_latency", oe_cyc - c0, 19);
        chk("to_data", oe_data, 8'hFF);
        chk("to_oe_count", oe_count, 9);
        chk("to_cs_low", cs_low, 25);

        // ch0 and ch3 both decode 0x10
        ack_delay = 1;
        io(1'b1, 6'h10, 8'hA7, 8, c0);
        chk("prio_req_count", req_count, 1);
        chk("prio_req_val", req_val, 4'b0001);
        chk("prio_data", req_data, 8'hA7);

        // unmapped port
        io(1'b0, 6'h3F, 8'h00, 8, c0);
        chk("nomatch_req_count", req_count, 0);
        chk("nomatch_cs_low", cs_low, 0);
        chk("nomatch_oe_count", oe_count, 0);

        // release during WAIT, ack arrives afterwards
        ack_delay = 8;
        io(1'b0, 6'h26, 8'h00, 5, c0);
        idle(6);
        chk("abort_req_count", req_count, 1);
        chk("abort_oe_count", oe_count, 0);
        chk("abort_cs_low", cs_low, 5);

        // both strobes fall together
        clear_mon();
        bus.A         = 6'h26;
        bus.rd_iorq_n = 1'b0;
        bus.wr_iorq_n = 1'b0;
        idle(8);
        bus.rd_iorq_n = 1'b1;
        bus.wr_iorq_n = 1'b1;
        idle(6);
        chk("both_req_count", req_count, 0);
        chk("both_cs_low", cs_low, 0);

        // reset in the middle of a read HOLD
        ack_delay = 2;
        clear_mon();
        bus.A         = 6'h26;
        bus.rd_iorq_n = 1'b0;
        idle(8);
        chk("hold_before_rst", bus.cd_oe, 1);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_cd_oe", bus.cd_oe, 0);
        chk("arst_cs_n", bus.cs_n, 1);
        chk("arst_cd_out", bus.cd_out, 8'h00);
        chk("arst_ch_req", bus.ch_req, 0);
        chk("arst_ch_wr", bus.ch_wr, 0);
        chk("arst_ch_data_out", bus.ch_data_out, 8'h00);
        bus.rd_iorq_n = 1'b1;
        repeat (4) @(posedge clk);
        #2 reset_n = 1'b1;
        idle(4);

        // recovery: write to ch3 range
        ack_delay = 1;
        io(1'b1, 6'h13, 8'h3C, 8, c0);
        chk("rec_req_val", req_val, 4'b1000);
        chk("rec_data", req_data, 8'h3C);
        chk("rec_latency", req_cyc - c0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
